spi_bus_arbiter: RTL and testbench

//  Shares one spi_master between two requesters: req 0 = UART command path, req 1 = periodic BMP280 sampler.

---
 rtl/spi_arb_pkg.sv | 24 ++
 rtl/rr_arbiter_2.sv | 27 ++
 rtl/spi_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the two-requester SPI bus arbiter.
// Consumers: spi_bus_arbiter and rr_arbiter_2 (ARB_FIXED_PRIO_EN selects fixed priority there).
package spi_arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    function automatic logic [NREQ-1:0] idx_onehot(input logic idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// Select field idx (width w) out of a flat per-requester vector.
`ifndef ARB_SLICE
`define ARB_SLICE(vec, idx, w) vec[int'(idx)*(w) +: (w)]
`endif

// File: rtl/rr_arbiter_2.sv
// Combinational two-way winner select.
// Default: round-robin on last_served. ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
module rr_arbiter_2
    import spi_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last_served,
    output logic            win,
    output logic            any
);

    always_comb begin
        any = |req;
        win = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        win = ~req[0];
`else
        // On a tie the requester that was not served last goes first.
        if (req == 2'b11) begin
            win = ~last_served;
        end else begin
            win = req[1];
        end
`endif
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_master between the UART command path (req 0) and the BMP280 sampler (req 1),
// holding the grant for a whole burst. Optional macro ARB_FIXED_PRIO_EN (see rr_arbiter_2).
// Handshake: a requester holds req (level) until it sees its done pulse; it must drop req in the
// done cycle or it is arbitrated again. word_ready/rsp_valid/done only ever reach the owner.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int WORDS_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_tied_ss,
    input  logic [NREQ*WORDS_W-1:0]   req_words,
    input  logic [NREQ*DATA_BITS-1:0] req_data,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           word_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATA_BITS-1:0]      rsp_data,
    output logic [NREQ-1:0]           done,
    output logic                      spi_en,
    output logic                      spi_tied_ss,
    output logic [DATA_BITS-1:0]      spi_data_out,
    output logic [WORDS_W-1:0]        spi_words,
    input  logic                      spi_ready_in,
    input  logic                      spi_valid_in,
    input  logic [DATA_BITS-1:0]      spi_data_in,
    output arb_state_e                state_dbg
);

    arb_state_e             state, state_nxt;
    logic                   owner;
    logic                   last_served;
    logic                   tied_q;
    logic [WORDS_W-1:0]     words_q;
    logic [WORDS_W-1:0]     cnt;
    logic [WORDS_W-1:0]     cnt_inc;
    logic [NREQ-1:0]        grant_q;
    logic [NREQ-1:0]        rsp_valid_q;
    logic [DATA_BITS-1:0]   rsp_data_q;
    logic                   win_idx;
    logic                   req_any;
    logic                   take;
    logic                   active;

    rr_arbiter_2 u_arb (
        .req         (req),
        .last_served (last_served),
        .win         (win_idx),
        .any         (req_any)
    );

    assign take    = spi_ready_in && req_any;
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = (`ARB_SLICE(req_words, win_idx, WORDS_W) == '0) ? DONE : START;
                end
            end
            START: state_nxt = XFER;
            XFER: begin
                if (spi_valid_in && (cnt_inc == words_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active       = (state == START) || (state == XFER);
        spi_en       = (state == START);
        spi_tied_ss  = active && tied_q;
        spi_words    = '0;
        spi_data_out = '0;
        word_ready   = '0;
        done         = '0;
        if (active) begin
            spi_words    = words_q;
            spi_data_out = `ARB_SLICE(req_data, owner, DATA_BITS);
        end
        if (state == XFER && spi_ready_in) begin
            word_ready = idx_onehot(owner);
        end
        if (state == DONE) begin
            done = idx_onehot(owner);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            tied_q      <= 1'b0;
            words_q     <= '0;
            cnt         <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (take) begin
                        owner   <= win_idx;
                        words_q <= `ARB_SLICE(req_words, win_idx, WORDS_W);
                        tied_q  <= req_tied_ss[win_idx];
                        grant_q <= idx_onehot(win_idx);
                    end
                end
                START: cnt <= '0;
                XFER: begin
                    if (spi_valid_in) begin
                        rsp_data_q  <= spi_data_in;
                        rsp_valid_q <= idx_onehot(owner);
                        cnt         <= cnt_inc;
                    end
                end
                DONE: begin
                    grant_q     <= '0;
                    last_served <= owner;
                end
                default: ;
            endcase
        end
    end

    assign grant     = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: behavioural spi_master model plus a response scoreboard.
module tb_spi_bus_arbiter;
    import spi_arb_pkg::*;

    localparam int DB = 8;
    localparam int WW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req = '0;
    logic [1:0]        req_tied_ss = '0;
    logic [2*WW-1:0]   req_words = '0;
    logic [2*DB-1:0]   req_data = '0;
    logic [1:0]        grant, word_ready, rsp_valid, done;
    logic [DB-1:0]     rsp_data, spi_data_out;
    logic              spi_en, spi_tied_ss;
    logic [WW-1:0]     spi_words;
    logic              spi_ready_in = 1'b1;
    logic              spi_valid_in = 1'b0;
    logic [DB-1:0]     spi_data_in = '0;
    arb_state_e        state_dbg;

    int                checks = 0;
    int                errors = 0;
    logic [DB+1:0]     exp_q[$];
    int                vcnt[2] = '{0, 0};
    int                en_cnt = 0;
    logic              inject = 1'b0;

    bit                m_busy = 1'b0;
    int                m_timer = 0;
    int                m_left = 0;
    logic [DB-1:0]     m_cap = '0;

    spi_bus_arbiter #(.DATA_BITS(DB), .WORDS_W(WW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tied_ss(req_tied_ss),
        .req_words(req_words), .req_data(req_data), .grant(grant),
        .word_ready(word_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .done(done), .spi_en(spi_en), .spi_tied_ss(spi_tied_ss),
        .spi_data_out(spi_data_out), .spi_words(spi_words),
        .spi_ready_in(spi_ready_in), .spi_valid_in(spi_valid_in),
        .spi_data_in(spi_data_in), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // spi_master model: 3 busy cycles per word, answers captured MOSI ^ 8'h5A.
    always @(posedge clk) begin
        #2;
        spi_valid_in = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            spi_ready_in = 1'b1;
        end else if (inject) begin
            spi_valid_in = 1'b1;
            spi_data_in = 8'hEE;
            inject = 1'b0;
        end else if (!m_busy) begin
            if (spi_en) begin
                m_busy = 1'b1;
                m_left = int'(spi_words);
                m_timer = 3;
                m_cap = spi_data_out;
                spi_ready_in = 1'b0;
            end
        end else if (m_timer != 0) begin
            m_timer--;
            spi_ready_in = 1'b0;
        end else begin
            spi_valid_in = 1'b1;
            spi_data_in = m_cap ^ 8'h5A;
            spi_ready_in = 1'b1;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
            end else begin
                m_timer = 3;
                m_cap = spi_data_out;
            end
        end
    end

    // Scoreboard: each rsp_valid must match the head of exp_q as {owner, data}.
    always @(negedge clk) begin
        logic [DB+1:0] e;
        if (!rst) begin
            if (spi_en) en_cnt++;
            if (rsp_valid[0]) vcnt[0]++;
            if (rsp_valid[1]) vcnt[1]++;
            if (rsp_valid != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got valid=%b data=%h, required no response", rsp_valid, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_valid, rsp_data} !== e) begin
                        errors++;
                        $display("FAIL rsp_word: got %b/%h, required %b/%h", rsp_valid, rsp_data, e[DB+1:DB], e[DB-1:0]);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] who, input logic [DB-1:0] d, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({who, d ^ 8'h5A});
    endtask

    task automatic wait_done(input int i, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1'b1;
                req[i] = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        req = '0;
        req_tied_ss = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({grant, word_ready, rsp_valid, done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_handshake: got %b, required 0", {grant, word_ready, rsp_valid, done});
        end
        checks++;
        if ({spi_en, spi_tied_ss, spi_words, spi_data_out, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_spi: got en=%b ss=%b w=%0d d=%h r=%h, required all 0",
                     spi_en, spi_tied_ss, spi_words, spi_data_out, rsp_data);
        end
        checks++;
        if (state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d, required IDLE", state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        int e0, v0;
        bit seen;
        req_words[WW-1:0] = 6'd3;
        req_data[DB-1:0] = 8'h3C;
        push_exp(2'b01, 8'h3C, 3);
        e0 = en_cnt;
        v0 = vcnt[0];
        req = 2'b01;
        @(negedge clk);
        checks++;
        if ({spi_en, grant, spi_words} !== {1'b1, 2'b01, 6'd3}) begin
            errors++;
            $display("FAIL single_start: got en=%b grant=%b words=%0d, required 1/01/3", spi_en, grant, spi_words);
        end
        @(negedge clk);
        checks++;
        if (spi_en !== 1'b0 || state_dbg !== XFER) begin
            errors++;
            $display("FAIL single_en_width: got en=%b state=%0d, required 0/XFER", spi_en, state_dbg);
        end
        wait_done(0, 100, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL single_done: got no done[0], required one"); end
        repeat (2) @(negedge clk);
        checks++;
        if (en_cnt - e0 != 1 || vcnt[0] - v0 != 3 || exp_q.size() != 0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL single_counts: got en=%0d rsp=%0d left=%0d grant=%b, required 1/3/0/00",
                     en_cnt - e0, vcnt[0] - v0, exp_q.size(), grant);
        end
    endtask

    task automatic test_simultaneous();
        bit seen;
        do_reset();
        req_words = {6'd2, 6'd2};
        req_data = {8'h22, 8'h11};
        push_exp(2'b01, 8'h11, 2);
`ifdef ARB_FIXED_PRIO_EN
        push_exp(2'b01, 8'h11, 2);
`endif
        push_exp(2'b10, 8'h22, 2);
        req = 2'b11;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL simul_first: got %b, required 01", grant); end
        wait_done(0, 100, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL simul_done0: got no done[0], required one"); end
`ifdef ARB_FIXED_PRIO_EN
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL simul_fixed: got %b, required 01", grant); end
        wait_done(0, 100, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL simul_fixed_done: got no done[0], required one"); end
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL simul_second: got %b, required 10", grant); end
        wait_done(1, 100, seen);
        repeat (2) @(negedge clk);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_done1: got seen=%b left=%0d, required 1/0", seen, exp_q.size());
        end
    endtask

    task automatic test_zero_words();
        int e0;
        req_words[2*WW-1:WW] = 6'd0;
        e0 = en_cnt;
        req = 2'b10;
        @(negedge clk);
        checks++;
        if ({grant, done} !== 4'b1010) begin
            errors++;
            $display("FAIL zero_done: got grant=%b done=%b, required 10/10", grant, done);
        end
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (en_cnt != e0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL zero_no_en: got en=%0d grant=%b, required 0/00", en_cnt - e0, grant);
        end
    endtask

    task automatic test_hold_off();
        bit seen;
        int bad;
        req_words = {6'd1, 6'd5};
        req_data[DB-1:0] = 8'h77;
        push_exp(2'b01, 8'h77, 5);
        req = 2'b01;
        @(negedge clk);
        req[1] = 1'b1;
        seen = 1'b0;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done[0]) begin seen = 1'b1; req[0] = 1'b0; break; end
            checks++;
            if (grant !== 2'b01 || spi_data_out !== req_data[DB-1:0]) begin
                errors++;
                $display("FAIL hold_owner: got grant=%b mosi=%h, required 01/%h", grant, spi_data_out, req_data[DB-1:0]);
            end
            req_data[2*DB-1:DB] = 8'($urandom_range(0, 255));
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL hold_done0: got no done[0], required one"); end
        req_data[2*DB-1:DB] = 8'h99;
        push_exp(2'b10, 8'h99, 1);
        wait_done(1, 100, seen);
        repeat (2) @(negedge clk);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_done1: got seen=%b left=%0d, required 1/0", seen, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int v0;
        bit seen;
        req_words[WW-1:0] = 6'd4;
        req_data[DB-1:0] = 8'h40;
        push_exp(2'b01, 8'h40, 2);
        v0 = vcnt[0];
        req = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (vcnt[0] - v0 >= 2) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_words: got %0d words, required 2", vcnt[0] - v0); end
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, word_ready, rsp_valid, done, spi_en, spi_tied_ss, spi_words, spi_data_out, rsp_data} !== '0
            || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL rstmid_clear: got grant=%b en=%b w=%0d d=%h r=%h st=%0d, required all 0/IDLE",
                     grant, spi_en, spi_words, spi_data_out, rsp_data, state_dbg);
        end
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_words[WW-1:0] = 6'd1;
        req_data[DB-1:0] = 8'h0F;
        push_exp(2'b01, 8'h0F, 1);
        req = 2'b01;
        wait_done(0, 100, seen);
        repeat (2) @(negedge clk);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_restart: got seen=%b left=%0d, required 1/0", seen, exp_q.size());
        end
    endtask

    task automatic test_tied_ss();
        bit seen;
        int v0;
        logic [DB-1:0] r0;
        req_words[WW-1:0] = 6'd2;
        req_data[DB-1:0] = 8'hA1;
        req_tied_ss = 2'b01;
        push_exp(2'b01, 8'hA1, 2);
        req = 2'b01;
        @(negedge clk);
        checks++;
        if ({spi_en, spi_tied_ss} !== 2'b11) begin
            errors++;
            $display("FAIL tied_start: got en=%b ss=%b, required 1/1", spi_en, spi_tied_ss);
        end
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (done[0]) begin
                seen = 1'b1;
                req[0] = 1'b0;
                if (spi_tied_ss !== 1'b0) begin
                    errors++;
                    $display("FAIL tied_done: got ss=%b, required 0", spi_tied_ss);
                end
                break;
            end
            if (spi_tied_ss !== 1'b1) begin
                errors++;
                $display("FAIL tied_xfer: got ss=%b, required 1", spi_tied_ss);
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL tied_seen: got no done[0], required one"); end
        req_tied_ss = '0;
        repeat (2) @(negedge clk);
        v0 = vcnt[0] + vcnt[1];
        r0 = rsp_data;
        inject = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (vcnt[0] + vcnt[1] != v0 || rsp_data !== r0) begin
            errors++;
            $display("FAIL idle_valid: got rsp=%0d data=%h, required 0/%h", vcnt[0] + vcnt[1] - v0, rsp_data, r0);
        end
    endtask

    task automatic test_max_words();
        bit seen;
        int v0;
        req_words[2*WW-1:WW] = 6'd63;
        req_data[2*DB-1:DB] = 8'hC3;
        push_exp(2'b10, 8'hC3, 63);
        v0 = vcnt[1];
        req = 2'b10;
        wait_done(1, 600, seen);
        repeat (2) @(negedge clk);
        checks++;
        if (!seen || vcnt[1] - v0 != 63 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL max_words: got seen=%b rsp=%0d left=%0d, required 1/63/0", seen, vcnt[1] - v0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_simultaneous();
        test_zero_words();
        test_hold_off();
        test_reset_mid_burst();
        test_tied_ss();
        test_max_words();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
